// File: rtl/ieee754_alu.sv
// Single-cycle binary32 add/sub/mul/div/compare unit with registered outputs.
// Arithmetic truncates toward zero; denormal inputs are flushed to signed zero.
module ieee754_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] out,
    output logic        great_out,
    output logic        less_out,
    output logic        equal_out
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_CMP = 3'd4
    } op_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Saturating pack: biased exponent outside 1..254 becomes signed inf or signed zero.
    function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                         input logic [23:0] m);
        if (e >= 10'sd255)
            pack = {s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            pack = {s, 31'd0};
        else
            pack = {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] inf_of(input logic s);
        inf_of = {s, 8'hFF, 23'd0};
    endfunction

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        lzc24 = 5'd24;
        for (int i = 0; i < 24; i++)
            if (v[i]) lzc24 = 5'(23 - i);
    endfunction

    // ---------------- operand decode ----------------
    logic        a_sgn, b_sgn;
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, any_nan;
    logic [23:0] a_sig, b_sig;
    logic signed [9:0] e_a, e_b;

    assign a_sgn   = A[31];
    assign b_sgn   = B[31];
    assign a_exp   = A[30:23];
    assign b_exp   = B[30:23];
    assign a_frac  = A[22:0];
    assign b_frac  = B[22:0];
    assign a_zero  = (a_exp == 8'd0);
    assign b_zero  = (b_exp == 8'd0);
    assign a_inf   = (a_exp == 8'hFF) && (a_frac == 23'd0);
    assign b_inf   = (b_exp == 8'hFF) && (b_frac == 23'd0);
    assign a_nan   = (a_exp == 8'hFF) && (a_frac != 23'd0);
    assign b_nan   = (b_exp == 8'hFF) && (b_frac != 23'd0);
    assign any_nan = a_nan || b_nan;
    assign a_sig   = {1'b1, a_frac};
    assign b_sig   = {1'b1, b_frac};
    assign e_a     = $signed({2'b00, a_exp});
    assign e_b     = $signed({2'b00, b_exp});

    // ---------------- add / sub ----------------
    logic        add_sb, eff_sub, a_ge;
    logic        x_sgn;
    logic signed [9:0] x_e;
    logic [23:0] x_sig, y_sig, y_al;
    logic [7:0]  shift;
    logic [24:0] sum;
    logic [4:0]  lz;
    logic [31:0] add_res;

    // NOTE: every variable assigned in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        add_sb  = b_sgn ^ (op == OP_SUB);
        eff_sub = a_sgn ^ add_sb;
        a_ge    = {a_exp, a_frac} >= {b_exp, b_frac};
        x_sgn   = a_ge ? a_sgn : add_sb;
        x_e     = a_ge ? e_a : e_b;
        x_sig   = a_ge ? a_sig : b_sig;
        y_sig   = a_ge ? b_sig : a_sig;
        shift   = a_ge ? (a_exp - b_exp) : (b_exp - a_exp);
        y_al    = (shift >= 8'd25) ? 24'd0 : (y_sig >> shift);
        sum     = eff_sub ? ({1'b0, x_sig} - {1'b0, y_al})
                          : ({1'b0, x_sig} + {1'b0, y_al});
        lz      = lzc24(sum[23:0]);
        add_res = 32'd0;

        if (any_nan)
            add_res = QNAN;
        else if (a_inf && b_inf)
            add_res = eff_sub ? QNAN : inf_of(a_sgn);
        else if (a_inf)
            add_res = inf_of(a_sgn);
        else if (b_inf)
            add_res = inf_of(add_sb);
        else if (a_zero && b_zero)
            add_res = 32'd0;
        else if (a_zero)
            add_res = {add_sb, B[30:0]};
        else if (b_zero)
            add_res = A;
        else if (sum == 25'd0)
            add_res = 32'd0;
        else if (sum[24])
            add_res = pack(x_sgn, x_e + 10'sd1, sum[24:1]);
        else
            add_res = pack(x_sgn, x_e - $signed({5'd0, lz}), sum[23:0] << lz);
    end

    // ---------------- multiply ----------------
    logic        m_sgn;
    logic [24:0] prod_top;
    logic signed [9:0] mul_e;
    logic [31:0] mul_res;

    always_comb begin
        m_sgn    = a_sgn ^ b_sgn;
        // Product lies in [2^46, 2^48); keep the 25 bits above the truncated tail.
        prod_top = 25'((48'(a_sig) * 48'(b_sig)) >> 23);
        mul_e    = e_a + e_b - 10'sd127;
        mul_res  = 32'd0;

        if (any_nan)
            mul_res = QNAN;
        else if ((a_zero && b_inf) || (a_inf && b_zero))
            mul_res = QNAN;
        else if (a_inf || b_inf)
            mul_res = inf_of(m_sgn);
        else if (a_zero || b_zero)
            mul_res = {m_sgn, 31'd0};
        else if (prod_top[24])
            mul_res = pack(m_sgn, mul_e + 10'sd1, prod_top[24:1]);
        else
            mul_res = pack(m_sgn, mul_e, prod_top[23:0]);
    end

    // ---------------- divide ----------------
    logic [24:0] quo;
    logic signed [9:0] div_e;
    logic [31:0] div_res;

    always_comb begin
        // (a_sig * 2^24) / b_sig lies in (2^23, 2^25): 25 quotient bits.
        quo     = 25'({a_sig, 24'd0} / {24'd0, b_sig});
        div_e   = e_a - e_b + 10'sd127;
        div_res = 32'd0;

        if (any_nan)
            div_res = QNAN;
        else if ((a_zero && b_zero) || (a_inf && b_inf))
            div_res = QNAN;
        else if (a_zero)
            div_res = {m_sgn, 31'd0};
        else if (b_zero || a_inf)
            div_res = inf_of(m_sgn);
        else if (b_inf)
            div_res = {m_sgn, 31'd0};
        else if (quo[24])
            div_res = pack(m_sgn, div_e, quo[24:1]);
        else
            div_res = pack(m_sgn, div_e - 10'sd1, quo[23:0]);
    end

    // ---------------- compare ----------------
    // Map each operand to a signed integer whose order matches numeric order; +0 and -0 coincide.
    logic [30:0]        a_mag, b_mag;
    logic signed [31:0] a_key, b_key;
    logic               cmp_gt, cmp_lt, cmp_eq;

    always_comb begin
        a_mag  = a_zero ? 31'd0 : A[30:0];
        b_mag  = b_zero ? 31'd0 : B[30:0];
        a_key  = a_sgn ? -$signed({1'b0, a_mag}) : $signed({1'b0, a_mag});
        b_key  = b_sgn ? -$signed({1'b0, b_mag}) : $signed({1'b0, b_mag});
        cmp_gt = !any_nan && (a_key > b_key);
        cmp_lt = !any_nan && (a_key < b_key);
        cmp_eq = !any_nan && (a_key == b_key);
    end

    // ---------------- result select and output registers ----------------
    logic [31:0] nxt_out;
    logic        nxt_gt, nxt_lt, nxt_eq;

    always_comb begin
        nxt_out = 32'd0;
        nxt_gt  = 1'b0;
        nxt_lt  = 1'b0;
        nxt_eq  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: nxt_out = add_res;
            OP_MUL:         nxt_out = mul_res;
            OP_DIV:         nxt_out = div_res;
            OP_CMP: begin
                nxt_gt = cmp_gt;
                nxt_lt = cmp_lt;
                nxt_eq = cmp_eq;
            end
            default: ;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= 32'd0;
            great_out <= 1'b0;
            less_out  <= 1'b0;
            equal_out <= 1'b0;
        end else begin
            out       <= nxt_out;
            great_out <= nxt_gt;
            less_out  <= nxt_lt;
            equal_out <= nxt_eq;
        end
    end

endmodule

// File: tb/tb_ieee754_alu.sv
// Directed bench for ieee754_alu: expected results queue up as each operation
// is driven and are popped and compared one clock edge later.
module tb_ieee754_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op = 3'd5;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] out;
    logic        great_out, less_out, equal_out;

    typedef struct {
        string       tag;
        logic [31:0] out;
        logic [2:0]  gle;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [2:0] NONE = 3'b000, GT = 3'b100, LT = 3'b010, EQ = 3'b001;

    ieee754_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .A         (a),
        .B         (b),
        .out       (out),
        .great_out (great_out),
        .less_out  (less_out),
        .equal_out (equal_out)
    );

    always #5 clk = ~clk;

    task automatic compare(input exp_t item);
        checks++;
        assert (out === item.out) else begin
            errors++;
            $error("FAIL %s out: got %h expected %h", item.tag, out, item.out);
        end
        checks++;
        assert ({great_out, less_out, equal_out} === item.gle) else begin
            errors++;
            $error("FAIL %s flags(g,l,e): got %b expected %b", item.tag,
                   {great_out, less_out, equal_out}, item.gle);
        end
    endtask

    task automatic check_now(input string tag, input logic [31:0] eo, input logic [2:0] gle);
        exp_t item;
        item.tag = tag;
        item.out = eo;
        item.gle = gle;
        compare(item);
    endtask

    // Drive one operation, queue its expected result, and check it right after the next edge.
    task automatic step(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eo, input logic [2:0] gle);
        exp_t item;
        item.tag = tag;
        item.out = eo;
        item.gle = gle;
        sb.push_back(item);
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard: got empty expected 1 entry", tag);
        end else begin
            compare(sb.pop_front());
        end
    endtask

    initial begin
        // Reset held: outputs stay clear even while clock runs with a live op.
        op = 3'd0; a = 32'h4080_0000; b = 32'h3F80_0000;
        repeat (2) @(posedge clk);
        #1 check_now("reset_held", 32'h0, NONE);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_now("reset_released_no_edge", 32'h0, NONE);

        step("noop5_zero", 3'd5, 32'h0, 32'h0, 32'h0, NONE);
        step("noop5_zero_b", 3'd5, 32'h0, 32'h0, 32'h0, NONE);

        // Add / sub
        step("add_4_1",      3'd0, 32'h4080_0000, 32'h3F80_0000, 32'h40A0_0000, NONE);
        step("add_neg",      3'd0, 32'hC0B0_0000, 32'hC090_0000, 32'hC120_0000, NONE);
        step("add_align",    3'd0, 32'h4020_0000, 32'h4104_CCCC, 32'h412C_CCCC, NONE);
        step("sub_122_2",    3'd1, 32'h42F4_0000, 32'h4000_0000, 32'h42F0_0000, NONE);
        step("sub_cancel",   3'd1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h0000_0000, NONE);
        step("add_mixed",    3'd0, 32'h3F80_0000, 32'hC080_0000, 32'hC040_0000, NONE);
        step("add_bigshift", 3'd0, 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, NONE);
        step("sub_zero_a",   3'd1, 32'h0000_0000, 32'h4040_0000, 32'hC040_0000, NONE);
        step("add_denorm",   3'd0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, NONE);
        step("add_ovf",      3'd0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, NONE);
        step("add_inf",      3'd0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, NONE);
        step("sub_inf_inf",  3'd1, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, NONE);
        step("add_nan",      3'd0, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, NONE);

        // Mul / div
        step("mul_16_8",     3'd2, 32'h4180_0000, 32'h4100_0000, 32'h4300_0000, NONE);
        step("mul_neg",      3'd2, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, NONE);
        step("mul_ovf",      3'd2, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, NONE);
        step("mul_unf",      3'd2, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, NONE);
        step("mul_szero",    3'd2, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, NONE);
        step("mul_0_inf",    3'd2, 32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, NONE);
        step("div_2_4",      3'd3, 32'h4000_0000, 32'h4080_0000, 32'h3F00_0000, NONE);
        step("div_1_3",      3'd3, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, NONE);
        step("div_by_zero",  3'd3, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, NONE);
        step("div_neg_by_0", 3'd3, 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, NONE);
        step("div_0_0",      3'd3, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, NONE);
        step("div_inf_inf",  3'd3, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, NONE);

        // Compare
        step("cmp_gt",       3'd4, 32'h3FC0_0000, 32'hBFC0_0000, 32'h0, GT);
        step("cmp_lt",       3'd4, 32'hBFC0_0000, 32'h3FC0_0000, 32'h0, LT);
        step("cmp_pz_nz",    3'd4, 32'h0000_0000, 32'h8000_0000, 32'h0, EQ);
        step("cmp_nan",      3'd4, 32'h7FC0_0000, 32'h3F80_0000, 32'h0, NONE);
        step("cmp_negs",     3'd4, 32'hBF80_0000, 32'hC000_0000, 32'h0, GT);
        step("cmp_same",     3'd4, 32'h4040_0000, 32'h4040_0000, 32'h0, EQ);

        // No-ops clear everything on the next edge
        step("noop6",        3'd6, 32'h4080_0000, 32'h3F80_0000, 32'h0, NONE);
        step("noop7",        3'd7, 32'h3FC0_0000, 32'hBFC0_0000, 32'h0, NONE);

        // Asynchronous reset mid-run: clears between edges
        step("add_pre_rst",  3'd0, 32'h4080_0000, 32'h3F80_0000, 32'h40A0_0000, NONE);
        #2 rst_n = 1'b0;
        #1 check_now("async_reset", 32'h0, NONE);
        #2 rst_n = 1'b1;
        step("after_rst",    3'd4, 32'h3FC0_0000, 32'hBFC0_0000, 32'h0, GT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
